// File: rtl/alu_issue.sv
// alu_issue: in-order issue stage in front of a fixed-latency ALU; buffers decode ops in a small FIFO and tags results.
// Latency: accept->ALU enable 2 cycles (1 with ALU_ISSUE_BYPASS_EN into an empty FIFO); ALU enable->res_valid ALU_LAT+1.
// Backpressure: in_ready drops on a full FIFO (registered count), during flush and during rst; mfhi/mflo wait for hi/lo writers.
//
// Ports: clk/rst (sync, active-high), flush; decode side in_valid/in_ready + in_a/in_b/in_ctrl/in_shamt/in_tag;
//        ALU side alu_dataIn/alu_ctrl/alu_shamt/alu_en_n out, alu_dataOut/alu_status in;
//        result side res_valid/res_data/res_status/res_tag.
// Optional: define ALU_ISSUE_BYPASS_EN to let an op accepted into an empty FIFO go straight to the issue register.
module alu_issue #(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 4,
    parameter int SHAMT_WIDTH  = 5,
    parameter int STATUS_WIDTH = 4,
    parameter int TAG_WIDTH    = 4,
    parameter int DEPTH        = 4,
    parameter int ALU_LAT      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_a,
    input  logic [DATA_WIDTH-1:0]     in_b,
    input  logic [CTRL_WIDTH-1:0]     in_ctrl,
    input  logic [SHAMT_WIDTH-1:0]    in_shamt,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic [2*DATA_WIDTH-1:0]   alu_dataIn,
    output logic [CTRL_WIDTH-1:0]     alu_ctrl,
    output logic [SHAMT_WIDTH-1:0]    alu_shamt,
    output logic                      alu_en_n,
    input  logic [DATA_WIDTH-1:0]     alu_dataOut,
    input  logic [STATUS_WIDTH-1:0]   alu_status,
    output logic                      res_valid,
    output logic [DATA_WIDTH-1:0]     res_data,
    output logic [STATUS_WIDTH-1:0]   res_status,
    output logic [TAG_WIDTH-1:0]      res_tag
);

    localparam int AW        = $clog2(DEPTH);
    localparam int SHAMT_LSB = TAG_WIDTH;
    localparam int CTRL_LSB  = SHAMT_LSB + SHAMT_WIDTH;
    localparam int OPS_LSB   = CTRL_LSB + CTRL_WIDTH;
    localparam int EW        = OPS_LSB + 2*DATA_WIDTH;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    // mult/mthi/mtlo style ops write hi/lo; mfhi/mflo read them.
    function automatic logic is_hilo_wr(input logic [CTRL_WIDTH-1:0] c);
        return (c == CTRL_WIDTH'(4'h6)) || (c == CTRL_WIDTH'(4'hD)) || (c == CTRL_WIDTH'(4'hE));
    endfunction

    function automatic logic is_hilo_rd(input logic [CTRL_WIDTH-1:0] c);
        return (c == CTRL_WIDTH'(4'hB)) || (c == CTRL_WIDTH'(4'hC));
    endfunction

    logic [EW-1:0]            mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]              cnt_q, cnt_d;

    logic                     en_n_q;
    logic [2*DATA_WIDTH-1:0]  ops_q;
    logic [CTRL_WIDTH-1:0]    ctrl_q;
    logic [SHAMT_WIDTH-1:0]   shamt_q;
    logic [TAG_WIDTH-1:0]     tag_q;

    logic [ALU_LAT-1:0]       trk_vld_q;
    logic [ALU_LAT-1:0]       trk_hilo_q;
    logic [TAG_WIDTH-1:0]     trk_tag_q [ALU_LAT];

    logic                     res_vld_q;
    logic [DATA_WIDTH-1:0]    res_dat_q;
    logic [STATUS_WIDTH-1:0]  res_sts_q;
    logic [TAG_WIDTH-1:0]     res_tag_q;

    logic [EW-1:0]            in_entry, head, iss_entry;
    logic                     accept, bypass, push, pop, issue;
    logic                     hilo_busy, head_blocked;

    assign in_ready = !rst && !flush && (cnt_q < CNT_FULL);
    assign accept   = in_valid && in_ready;
    assign in_entry = {in_a, in_b, in_ctrl, in_shamt, in_tag};
    assign head     = mem_q[rd_ptr_q];

    // A hi/lo writer is outstanding from the cycle it sits in the issue
    // register until it has left the last tracking stage.
    assign hilo_busy    = (!en_n_q && is_hilo_wr(ctrl_q)) || (|(trk_vld_q & trk_hilo_q));
    assign head_blocked = is_hilo_rd(head[CTRL_LSB +: CTRL_WIDTH]) && hilo_busy;

`ifdef ALU_ISSUE_BYPASS_EN
    // Registered count==0 guarantees no older op is waiting, so order holds.
    assign bypass = accept && (cnt_q == '0) && !(is_hilo_rd(in_ctrl) && hilo_busy);
`else
    assign bypass = 1'b0;
`endif

    assign push      = accept && !bypass;
    assign pop       = (cnt_q != '0) && !head_blocked && !flush;
    assign issue     = pop || bypass;
    assign iss_entry = bypass ? in_entry : head;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is not reset; push is impossible while rst or flush is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            en_n_q     <= 1'b1;
            ops_q      <= '0;
            ctrl_q     <= '0;
            shamt_q    <= '0;
            tag_q      <= '0;
            trk_vld_q  <= '0;
            trk_hilo_q <= '0;
            for (int i = 0; i < ALU_LAT; i++) trk_tag_q[i] <= '0;
            res_vld_q  <= 1'b0;
            res_dat_q  <= '0;
            res_sts_q  <= '0;
            res_tag_q  <= '0;
        end else if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            en_n_q    <= 1'b1;
            trk_vld_q <= '0;
            res_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            en_n_q   <= !issue;
            if (issue) begin
                ops_q   <= iss_entry[OPS_LSB +: 2*DATA_WIDTH];
                ctrl_q  <= iss_entry[CTRL_LSB +: CTRL_WIDTH];
                shamt_q <= iss_entry[SHAMT_LSB +: SHAMT_WIDTH];
                tag_q   <= iss_entry[TAG_WIDTH-1:0];
            end
            // Stage 0 follows the cycle the ALU enable is low, so the last
            // stage lines up with the cycle alu_dataOut is valid.
            trk_vld_q[0]  <= !en_n_q;
            trk_hilo_q[0] <= is_hilo_wr(ctrl_q);
            trk_tag_q[0]  <= tag_q;
            for (int i = 1; i < ALU_LAT; i++) begin
                trk_vld_q[i]  <= trk_vld_q[i-1];
                trk_hilo_q[i] <= trk_hilo_q[i-1];
                trk_tag_q[i]  <= trk_tag_q[i-1];
            end
            res_vld_q <= trk_vld_q[ALU_LAT-1];
            if (trk_vld_q[ALU_LAT-1]) begin
                res_dat_q <= alu_dataOut;
                res_sts_q <= alu_status;
                res_tag_q <= trk_tag_q[ALU_LAT-1];
            end
        end
    end

    assign alu_dataIn = ops_q;
    assign alu_ctrl   = ctrl_q;
    assign alu_shamt  = shamt_q;
    assign alu_en_n   = en_n_q;
    assign res_valid  = res_vld_q;
    assign res_data   = res_dat_q;
    assign res_status = res_sts_q;
    assign res_tag    = res_tag_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a behavioural ALU (add, mult with hi/lo, mfhi/mflo).
// Latency: expected issue/result cycles are hand-computed constants for ALU_LAT=2, with or without bypass.
// Backpressure: the bench holds each offered op until in_ready, and checks refusal cycles on a full FIFO.
module tb_alu_issue;

    localparam int LAT = 2;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam int ACC2ISS = 1;
    int acc_exp [8] = '{0, 1, 2, 3, 4, 5, 6, 10};
`else
    localparam int ACC2ISS = 2;
    int acc_exp [8] = '{0, 1, 2, 3, 4, 6, 7, 11};
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_ctrl, in_tag;
    logic [4:0]  in_shamt;
    logic [63:0] alu_dataIn;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_shamt;
    logic        alu_en_n;
    logic [31:0] alu_dataOut;
    logic [3:0]  alu_status;
    logic        res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_status, res_tag;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    alu_issue #(
        .DATA_WIDTH(32), .CTRL_WIDTH(4), .SHAMT_WIDTH(5), .STATUS_WIDTH(4),
        .TAG_WIDTH(4), .DEPTH(4), .ALU_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_shamt(in_shamt), .in_tag(in_tag),
        .alu_dataIn(alu_dataIn), .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt), .alu_en_n(alu_en_n),
        .alu_dataOut(alu_dataOut), .alu_status(alu_status),
        .res_valid(res_valid), .res_data(res_data), .res_status(res_status), .res_tag(res_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: result valid LAT cycles after the enable-low cycle.
    logic [31:0] md [LAT];
    logic [3:0]  ms [LAT];
    logic [31:0] hi_r, lo_r;
    always @(posedge clk) begin
        logic [31:0] a, b, r;
        logic [32:0] sum;
        logic [63:0] prod;
        logic        c;
        a    = alu_dataIn[63:32];
        b    = alu_dataIn[31:0];
        sum  = {1'b0, a} + {1'b0, b};
        prod = {32'b0, a} * {32'b0, b};
        r    = a;
        c    = 1'b0;
        if (alu_en_n === 1'b0) begin
            case (alu_ctrl)
                4'h4: begin r = sum[31:0]; c = sum[32]; end
                4'h6: begin r = prod[31:0]; hi_r <= prod[63:32]; lo_r <= prod[31:0]; end
                4'hB: r = hi_r;
                4'hC: r = lo_r;
                default: r = a;
            endcase
        end
        md[0] <= r;
        ms[0] <= {1'b0, c, r[31], (r == 32'd0)};
        for (int i = 1; i < LAT; i++) begin
            md[i] <= md[i-1];
            ms[i] <= ms[i-1];
        end
    end
    assign alu_dataOut = md[LAT-1];
    assign alu_status  = ms[LAT-1];

    // Event logs
    int          iss_cyc [$];
    logic [63:0] iss_dat [$];
    logic [4:0]  iss_sh  [$];
    int          res_cyc [$];
    logic [31:0] res_dat [$];
    logic [3:0]  res_tg  [$];
    logic [3:0]  res_st  [$];

    always @(negedge clk) begin
        if (alu_en_n === 1'b0) begin
            iss_cyc.push_back(cyc);
            iss_dat.push_back(alu_dataIn);
            iss_sh.push_back(alu_shamt);
        end
        if (res_valid === 1'b1) begin
            res_cyc.push_back(cyc);
            res_dat.push_back(res_data);
            res_tg.push_back(res_tag);
            res_st.push_back(res_status);
        end
    end

    function automatic int gic(int i);
        if (i < iss_cyc.size()) return iss_cyc[i];
        return -1;
    endfunction
    function automatic logic [63:0] gid(int i);
        if (i < iss_dat.size()) return iss_dat[i];
        return '1;
    endfunction
    function automatic int grc(int i);
        if (i < res_cyc.size()) return res_cyc[i];
        return -1;
    endfunction
    function automatic logic [31:0] grd(int i);
        if (i < res_dat.size()) return res_dat[i];
        return 32'hDEAD_BEEF;
    endfunction
    function automatic logic [3:0] grt(int i);
        if (i < res_tg.size()) return res_tg[i];
        return 4'hx;
    endfunction
    function automatic logic [3:0] grs(int i);
        if (i < res_st.size()) return res_st[i];
        return 4'hx;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op and hold it until accepted; acc is the accept cycle or -1.
    task automatic offer(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] t, output int acc);
        bit done = 0;
        in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b; in_shamt = sh; in_tag = t;
        acc = -1;
        #1;
        for (int n = 0; n < 40 && !done; n++) begin
            if (in_ready) begin
                acc  = cyc;
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_iss(input int n);
        for (int k = 0; k < 60 && iss_cyc.size() < n; k++) tick();
    endtask

    task automatic wait_res(input int n);
        for (int k = 0; k < 60 && res_cyc.size() < n; k++) tick();
    endtask

    logic [3:0]  f_ctrl [8] = '{4'h6, 4'hC, 4'h6, 4'hC, 4'h4, 4'h4, 4'h4, 4'h4};
    logic [31:0] f_a    [8] = '{3, 0, 10, 0, 3, 4, 5, 6};
    logic [31:0] f_b    [8] = '{4, 0, 10, 0, 1, 1, 1, 1};
    logic [3:0]  f_tag  [8] = '{9, 0, 1, 2, 3, 4, 5, 6};
    logic [31:0] f_res  [8] = '{12, 12, 100, 100, 4, 5, 6, 7};

    initial begin
        int acc, acc2, ib, rb, ifl;
        int accs [8];

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1;
        in_a = 32'h11; in_b = 32'h22; in_ctrl = 4'h4; in_shamt = 5'd0; in_tag = 4'hF;

        // Reset held three cycles with an op offered
        repeat (3) begin
            tick();
            check("rst_in_ready", in_ready, 0);
            check("rst_en_n", alu_en_n, 1);
            check("rst_res_valid", res_valid, 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_en_n", alu_en_n, 1);
        check("post_rst_dataIn", alu_dataIn, 0);
        check("post_rst_ctrl", alu_ctrl, 0);
        check("post_rst_res_data", res_data, 0);
        check("post_rst_res_tag", res_tag, 0);
        check("post_rst_res_status", res_status, 0);
        check("post_rst_no_issue", iss_cyc.size(), 0);
        repeat (3) tick();

        // Single add: 5 + 7, tag 3
        ib = iss_cyc.size(); rb = res_cyc.size();
        offer(4'h4, 32'd5, 32'd7, 5'd9, 4'd3, acc);
        wait_iss(ib + 1);
        wait_res(rb + 1);
        repeat (4) tick();
        check("add_acc2iss", gic(ib) - acc, ACC2ISS);
        check("add_dataIn", gid(ib), {32'd5, 32'd7});
        check("add_shamt", (ib < iss_sh.size()) ? iss_sh[ib] : 5'h1F, 5'd9);
        check("add_en_once", iss_cyc.size() - ib, 1);
        check("add_iss2res", grc(rb) - gic(ib), LAT + 1);
        check("add_res_data", grd(rb), 32'd12);
        check("add_res_tag", grt(rb), 4'd3);
        check("add_res_status", grs(rb), 4'h0);
        check("add_res_once", res_cyc.size() - rb, 1);
        check("add_res_hold", res_data, 32'd12);

        // Interlock: mult 6*7 then mflo
        ib = iss_cyc.size(); rb = res_cyc.size();
        offer(4'h6, 32'd6, 32'd7, 5'd0, 4'd5, acc);
        offer(4'hC, 32'd0, 32'd0, 5'd0, 4'd6, acc2);
        wait_res(rb + 2);
        repeat (3) tick();
        check("ilk_mult_acc2iss", gic(ib) - acc, ACC2ISS);
        check("ilk_gap", gic(ib + 1) - gic(ib), LAT + 2);
        check("ilk_mult_tag", grt(rb), 4'd5);
        check("ilk_mult_data", grd(rb), 32'd42);
        check("ilk_mflo_tag", grt(rb + 1), 4'd6);
        check("ilk_mflo_data", grd(rb + 1), 32'd42);
        check("ilk_mflo_iss2res", grc(rb + 1) - gic(ib + 1), LAT + 1);

        // Full FIFO behind interlocked mflo ops
        rb = res_cyc.size();
        for (int k = 0; k < 8; k++)
            offer(f_ctrl[k], f_a[k], f_b[k], 5'd0, f_tag[k], accs[k]);
        for (int k = 1; k < 8; k++)
            check($sformatf("full_acc_%0d", k), accs[k] - accs[0], acc_exp[k]);
        wait_res(rb + 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("full_tag_%0d", k), grt(rb + k), f_tag[k]);
            check($sformatf("full_data_%0d", k), grd(rb + k), f_res[k]);
        end
        repeat (4) tick();

        // Flush with a writer in flight and ops queued behind an mflo
        rb = res_cyc.size();
        offer(4'h6, 32'd3, 32'd5, 5'd0, 4'd1, acc);
        offer(4'hC, 32'd0, 32'd0, 5'd0, 4'd2, acc);
        offer(4'h4, 32'd1, 32'd1, 5'd0, 4'd3, acc);
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 4'h4; in_tag = 4'd4;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_en_n", alu_en_n, 1);
        check("flush_res_valid", res_valid, 0);
        check("flush_in_ready_after", in_ready, 1);
        ifl = iss_cyc.size();
        repeat (12) tick();
        check("flush_no_res", res_cyc.size() - rb, 0);
        check("flush_no_issue", iss_cyc.size() - ifl, 0);

        // First op after flush sees an empty FIFO; all-ones + 1 gives zero+carry
        ib = iss_cyc.size(); rb = res_cyc.size();
        offer(4'h4, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd7, acc);
        wait_iss(ib + 1);
        wait_res(rb + 1);
        check("post_flush_acc2iss", gic(ib) - acc, ACC2ISS);
        check("post_flush_data", grd(rb), 32'd0);
        check("post_flush_status", grs(rb), 4'h5);
        check("post_flush_tag", grt(rb), 4'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage directly upstream of the ALU. Accepts ALU operations from decode over a valid/ready handshake and buffers them in a small FIFO. Drives the ALU's packed operand bus, control, shift amount and active-low enable one operation per cycle. Tracks each operation's tag through the ALU's fixed latency, so every result leaves on a single registered result port with its tag and status flags. Holds back hi/lo reads (mfhi/mflo) while a hi/lo write is still in flight.

## Interface
- DATA_WIDTH, 32, operand/result width
- CTRL_WIDTH, 4, ALU opcode width
- SHAMT_WIDTH, 5, shift-amount width
- STATUS_WIDTH, 4, ALU flag width ({ovf,carry,sign,zero})
- TAG_WIDTH, 4, destination tag width
- DEPTH, 4, FIFO entries; power of two, >=2
- ALU_LAT, 1, cycles from the alu_en_n-low cycle until alu_dataOut/alu_status are valid; >=1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard queued and in-flight ops
- in_valid  in  1  decode offers an op
- in_ready  out  1  stage can accept
- in_a  in  DATA_WIDTH  first operand
- in_b  in  DATA_WIDTH  second operand
- in_ctrl  in  CTRL_WIDTH  opcode
- in_shamt  in  SHAMT_WIDTH  shift amount
- in_tag  in  TAG_WIDTH  destination tag
- alu_dataIn  out  2*DATA_WIDTH  packed operands, {in_a, in_b}
- alu_ctrl  out  CTRL_WIDTH  opcode to ALU
- alu_shamt  out  SHAMT_WIDTH  shift amount to ALU
- alu_en_n  out  1  low for exactly the cycles an op is issued
- alu_dataOut  in  DATA_WIDTH  ALU result
- alu_status  in  STATUS_WIDTH  ALU flags
- res_valid  out  1  one-cycle result strobe
- res_data  out  DATA_WIDTH  captured result
- res_status  out  STATUS_WIDTH  captured flags
- res_tag  out  TAG_WIDTH  tag of the result

## Operation
- **Handshake:** transfer when in_valid && in_ready. `in_ready = !rst && !flush && (count < DEPTH)`. count is the registered value, so a full FIFO accepts nothing that cycle, even if it pops.
- **FIFO:** DEPTH entries of {a, b, ctrl, shamt, tag}. Read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits. Push and pop in the same cycle leave count unchanged.
- **Issue register:** each cycle, if the head exists and is not interlocked, pop it. Load alu_dataIn, alu_ctrl and alu_shamt, and drive alu_en_n=0 the next cycle.
- **Idle issue:** otherwise alu_en_n=1 and alu_dataIn/alu_ctrl/alu_shamt hold their previous values.
- **Tracking pipeline:** an ALU_LAT-stage shift register of {valid, tag, hilo_wr}. Stage 0 is loaded in the issue cycle.
- **Result capture:** when the last stage is valid, capture alu_dataOut, alu_status and the tag into res_*, and pulse res_valid for one cycle. res_data/res_status/res_tag hold between strobes.
- **Hi/lo interlock:** a head op with ctrl 4'hB or 4'hC is not issued while any tracking stage, or the issue register itself, holds ctrl 4'h6, 4'hD or 4'hE. Younger ops wait behind it; issue stays in order.
- **Flush** (takes priority over everything except rst):
  - next cycle, pointers and count are zeroed;
  - all tracking valids are cleared;
  - alu_en_n=1;
  - res_valid=0.
  - An input offered in the flush cycle is not accepted.
- **Reset values:**
  - in_ready=0 while rst is high, 1 the cycle after release;
  - alu_en_n=1; alu_dataIn/alu_ctrl/alu_shamt=0;
  - res_valid=0; res_data/res_status/res_tag=0;
  - FIFO empty; all tracking valids 0.
- **Reset mid-operation:** queued and in-flight ops are lost with no result strobe.

## Timing
- **Throughput:** one issue per cycle when not interlocked; one result per cycle.
- **Accept to issue** (empty FIFO, no bypass): accepted in cycle T, alu_en_n low in cycle T+2.
- **Issue to result:** alu_en_n low in cycle I, res_valid high in cycle I+ALU_LAT+1.
- **Interlocked mfhi/mflo:** issues in the cycle after the last hi/lo writer leaves the final tracking stage.

## Configuration
- **ALU_ISSUE_BYPASS_EN defined:** when the FIFO is empty (registered count==0), accepting an op loads it straight into the issue register. The op does not enter the FIFO, and alu_en_n is low in T+1.
  - The bypass is blocked, and the op is queued, when the incoming op is mfhi/mflo and the interlock is active.
- **Undefined:** every op passes through the FIFO, and minimum accept-to-issue is 2 cycles.

## Test plan
- **Reset:** hold rst 3 cycles with in_valid=1 -> in_ready=0, alu_en_n=1, res_valid=0 throughout; in_ready=1 the cycle after release.
- **Single add:** a=5, b=7, ctrl=4'h4, tag=3 with ALU_LAT=1, ALU model returning 12 -> alu_dataIn={5,7}, alu_en_n low for 1 cycle; res_valid one cycle with res_data=12, res_tag=3, res_status zero flag 0.
- **Full FIFO:** hold the issue side by stalling behind an interlocked mflo, push 4 ops -> in_ready=0 after the 4th. The 5th op is not accepted until a pop, and tags come out in order 0,1,2,3.
- **Interlock:** mult (6×7) immediately followed by mflo, ALU_LAT=2 -> mflo issues only after the mult leaves the tracking pipeline; mflo result=42.
- **Flush:** flush with 3 ops queued and 1 in flight -> no res_valid afterward, in_ready=0 in the flush cycle, count=0 the next cycle.
- **Bypass:** with ALU_ISSUE_BYPASS_EN defined, an op accepted at T into an empty FIFO -> alu_en_n low at T+1.
- **No bypass:** with the macro undefined, the same op -> alu_en_n low at T+2.
